eth_frame_scheduler: RTL and testbench
======================================

# eth_frame_scheduler

Frame-level scheduler sharing the single RMII transmit path between the pixel source and the audio source. Grants one complete frame at a time to one requester, forwards its payload bytes to the downstream ethernet packager with frame delimiters and a type tag, then enforces the inter-frame gap before the next grant. Sits between the pixel/audio buffers and the header/data/tail packager that drives the dibit stream.

## Interface
- `PIX_BYTES`, 320: payload bytes per pixel frame (1..511)
- `AUD_BYTES`, 256: payload bytes per audio frame (1..511)
- `IFG_CYCLES`, 48: idle cycles after each frame (96 bit times at 2 bits/cycle), 1..255
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `pix_req` in 1: pixel source holds a complete frame
- `pix_valid` in 1, `pix_data` in 8: pixel payload byte
- `pix_ready` out 1: pixel byte accepted
- `aud_req` in 1: audio source holds a complete frame
- `aud_valid` in 1, `aud_data` in 8: audio payload byte
- `aud_ready` out 1: audio byte accepted
- `tx_ready` in 1: packager accepts a byte
- `tx_valid` out 1, `tx_data` out 8: payload byte to packager
- `tx_sof` out 1: qualifies first byte of frame
- `tx_eof` out 1: qualifies last byte of frame
- `tx_type` out 1: 0 = pixel, 1 = audio; stable for whole frame
- `busy` out 1: high in any state other than IDLE

## Operation
- States: IDLE, XFER, GAP.
- IDLE: if `pix_req` or `aud_req`, latch grant (`sel`) and `tx_type`, clear byte counter, go XFER. No request: stay.
- Arbitration: one request -> grant it. Both -> round-robin: grant the source not granted last. `last_grant` resets to audio, so pixel wins the first tie.
- XFER: `tx_valid = sel_valid`, `tx_data = sel_data`, `sel_ready = tx_ready`; non-selected ready held 0. Handshake = valid & ready. Counter (9 bits) increments per handshake. `tx_sof` = (count == 0) & `tx_valid`; `tx_eof` = (count == N-1) & `tx_valid`, N = PIX_BYTES or AUD_BYTES per grant.
- eof handshake: update `last_grant`, load gap counter with IFG_CYCLES, go GAP.
- Requests deasserting during XFER are ignored; frame length is set by the counter only.
- GAP: all readies 0, `tx_valid` 0; decrement gap counter; at 1 go IDLE.
- Source stall (valid low) in XFER: `tx_valid` low, counter holds, no timeout.
- Reset mid-frame: state IDLE, counters 0, `last_grant` audio; frame truncated with no eof; downstream must discard.

## Timing
- Reset values: `tx_valid`, `tx_sof`, `tx_eof`, `tx_type`, `pix_ready`, `aud_ready`, `busy` all 0; `tx_data` 0.
- Request sampled in IDLE at cycle t -> XFER and `busy` at t+1; first byte can transfer at t+1.
- XFER datapath is combinational pass-through: zero-cycle latency, one byte per cycle at full throughput.
- eof handshake at cycle e -> GAP for cycles e+1..e+IFG_CYCLES -> IDLE at e+IFG_CYCLES+1 -> earliest next XFER at e+IFG_CYCLES+2.
- `tx_type` and `sel` registered; change only on the IDLE->XFER transition.
- N = 1: sof and eof asserted on the same byte.

## Configuration
- `ETH_AUDIO_PRIORITY_EN` defined: audio has strict priority; on simultaneous requests audio always wins; `last_grant` still tracked but unused.
- Not defined: round-robin as above. No other behaviour differs.

## Structure
- `eth_sched_pkg`: state enum (IDLE, XFER, GAP), source enum (SRC_PIX = 0, SRC_AUD = 1), `CNT_W` = 9, `GAP_W` = 8.
- One sub-module: `rr_arbiter2` - two-request grant logic with `last_grant` register and the priority override under `ETH_AUDIO_PRIORITY_EN`.

## Test plan
- Only `pix_req`, PIX_BYTES=4, bytes 0xA0..0xA3 back-to-back -> `tx_data` A0..A3 on 4 consecutive cycles, sof on A0, eof on A3, `tx_type` 0, then 48 GAP cycles.
- Both requests held continuously -> grants alternate pixel, audio, pixel; eof-to-next-sof spacing exactly IFG_CYCLES+2 cycles.
- `tx_ready` low 3 cycles mid-frame -> counter holds, `tx_data` stable, source ready low, no byte lost or duplicated.
- `rst` pulsed at byte 2 of an audio frame -> next cycle all outputs 0, IDLE; following tie grants pixel.
- `ETH_AUDIO_PRIORITY_EN` defined, both requests held -> audio granted every frame, pixel never granted.
- AUD_BYTES=1 -> single byte with sof and eof both 1, `tx_type` 1.

Source files
------------

// File: rtl/eth_sched_pkg.sv
// Shared types and widths for the ethernet frame scheduler.
package eth_sched_pkg;

  localparam int CNT_W = 9;   // payload byte counter, frames up to 511 bytes
  localparam int GAP_W = 8;   // inter-frame gap counter, up to 255 cycles

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic {
    SRC_PIX = 1'b0,
    SRC_AUD = 1'b1
  } src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester frame arbiter: round-robin on ties, remembering the last
// completed grant. Build option ETH_AUDIO_PRIORITY_EN makes audio win every tie.
module rr_arbiter2
  import eth_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pix_req,
  input  logic aud_req,
  input  logic update,     // a frame just completed
  input  src_t done_src,   // source of the frame that completed
  output logic any_req,
  output src_t grant
);

  src_t last_grant_reg;

  // Remember who finished last; audio after reset so pixel wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= SRC_AUD;
    end else if (update) begin
      last_grant_reg <= done_src;
    end
  end

  // Grant decision for the current request pair.
  always_comb begin
    any_req = pix_req | aud_req;
    grant   = SRC_PIX;
    if (pix_req && aud_req) begin
`ifdef ETH_AUDIO_PRIORITY_EN
      grant = SRC_AUD;
`else
      grant = (last_grant_reg == SRC_AUD) ? SRC_PIX : SRC_AUD;
`endif
    end else if (aud_req) begin
      grant = SRC_AUD;
    end
  end

endmodule

// File: rtl/eth_frame_scheduler.sv
// Frame scheduler sharing the RMII transmit path between pixel and audio
// sources: one whole frame per grant, sof/eof/type tagging, then a fixed
// inter-frame gap. Optional build macro: ETH_AUDIO_PRIORITY_EN (audio wins ties).
module eth_frame_scheduler
  import eth_sched_pkg::*;
#(
  parameter int PIX_BYTES  = 320,
  parameter int AUD_BYTES  = 256,
  parameter int IFG_CYCLES = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_req,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  input  logic       aud_req,
  input  logic       aud_valid,
  input  logic [7:0] aud_data,
  output logic       aud_ready,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_sof,
  output logic       tx_eof,
  output logic       tx_type,
  output logic       busy
);

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_BYTES - 1);
  localparam logic [CNT_W-1:0] AUD_LAST = CNT_W'(AUD_BYTES - 1);
  localparam logic [GAP_W-1:0] IFG_LOAD = GAP_W'(IFG_CYCLES);

  state_t           state_reg, state_next;
  src_t             sel_reg, sel_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [GAP_W-1:0] gap_reg, gap_next;

  logic             any_req;
  src_t             grant;
  logic             frame_done;
  logic             sel_valid;
  logic [7:0]       sel_data;
  logic [CNT_W-1:0] last_idx;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .pix_req  (pix_req),
    .aud_req  (aud_req),
    .update   (frame_done),
    .done_src (sel_reg),
    .any_req  (any_req),
    .grant    (grant)
  );

  // State, grant and counters; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= SRC_PIX;
      count_reg <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      count_reg <= count_next;
      gap_reg   <= gap_next;
    end
  end

  // Next-state logic plus the zero-latency byte pass-through during XFER.
  always_comb begin
    sel_valid  = (sel_reg == SRC_AUD) ? aud_valid : pix_valid;
    sel_data   = (sel_reg == SRC_AUD) ? aud_data  : pix_data;
    last_idx   = (sel_reg == SRC_AUD) ? AUD_LAST  : PIX_LAST;

    state_next = state_reg;
    sel_next   = sel_reg;
    count_next = count_reg;
    gap_next   = gap_reg;
    frame_done = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    tx_sof     = 1'b0;
    tx_eof     = 1'b0;
    pix_ready  = 1'b0;
    aud_ready  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          sel_next   = grant;
          count_next = '0;
          state_next = XFER;
        end
      end

      XFER: begin
        tx_valid  = sel_valid;
        tx_data   = sel_data;
        pix_ready = (sel_reg == SRC_PIX) && tx_ready;
        aud_ready = (sel_reg == SRC_AUD) && tx_ready;
        tx_sof    = (count_reg == '0) && sel_valid;
        tx_eof    = (count_reg == last_idx) && sel_valid;
        // Frame length comes from the counter alone; requests are ignored here.
        if (sel_valid && tx_ready) begin
          if (count_reg == last_idx) begin
            frame_done = 1'b1;
            count_next = '0;
            gap_next   = IFG_LOAD;
            state_next = GAP;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end

      GAP: begin
        gap_next = gap_reg - 1'b1;
        if (gap_reg <= 1) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_type = sel_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_eth_frame_scheduler.sv
// Directed bench for eth_frame_scheduler with a byte scoreboard.
module tb_eth_frame_scheduler;

  localparam int IFG = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       pix_req, pix_valid, pix_ready;
  logic [7:0] pix_data;
  logic       aud_req, aud_valid, aud_ready;
  logic [7:0] aud_data;
  logic       tx_ready, tx_valid, tx_sof, tx_eof, tx_type, busy;
  logic [7:0] tx_data;

  logic       b_pix_req, b_pix_valid, b_pix_ready;
  logic [7:0] b_pix_data;
  logic       b_aud_req, b_aud_valid, b_aud_ready;
  logic [7:0] b_aud_data;
  logic       b_tx_ready, b_tx_valid, b_tx_sof, b_tx_eof, b_tx_type, b_busy;
  logic [7:0] b_tx_data;

  eth_frame_scheduler #(.PIX_BYTES(4), .AUD_BYTES(4), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst),
    .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .aud_req(aud_req), .aud_valid(aud_valid), .aud_data(aud_data), .aud_ready(aud_ready),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_type(tx_type), .busy(busy)
  );

  eth_frame_scheduler #(.PIX_BYTES(2), .AUD_BYTES(1), .IFG_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst),
    .pix_req(b_pix_req), .pix_valid(b_pix_valid), .pix_data(b_pix_data), .pix_ready(b_pix_ready),
    .aud_req(b_aud_req), .aud_valid(b_aud_valid), .aud_data(b_aud_data), .aud_ready(b_aud_ready),
    .tx_ready(b_tx_ready), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .tx_sof(b_tx_sof), .tx_eof(b_tx_eof), .tx_type(b_tx_type), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [10:0] exp_q[$];   // {type, sof, eof, data}

  int   pix_idx = 0;
  int   aud_idx = 0;
  logic pix_hs = 1'b0;
  logic aud_hs = 1'b0;
  int   last_sof = -1;
  int   last_eof = -1;
  bit   spacing_en = 1'b0;
  int   spacing_cnt = 0;

  logic       s_tx_valid, s_tx_sof, s_tx_eof, s_tx_type, s_busy, s_pix_ready, s_aud_ready;
  logic [7:0] s_tx_data;
  logic       sb_tx_valid, sb_tx_sof, sb_tx_eof, sb_tx_type, sb_busy, sb_aud_ready;
  logic [7:0] sb_tx_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic src, input int start, input int n);
    logic [7:0] base;
    base = src ? 8'hC0 : 8'hA0;
    for (int i = 0; i < n; i++)
      exp_q.push_back({src, i == 0, i == n - 1, 8'(base + start + i)});
  endtask

  // Sample at the falling edge, score handshakes, then let sources advance.
  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    cyc++;
    s_tx_valid = tx_valid; s_tx_sof = tx_sof; s_tx_eof = tx_eof; s_tx_type = tx_type;
    s_tx_data = tx_data; s_busy = busy; s_pix_ready = pix_ready; s_aud_ready = aud_ready;
    sb_tx_valid = b_tx_valid; sb_tx_sof = b_tx_sof; sb_tx_eof = b_tx_eof; sb_tx_type = b_tx_type;
    sb_tx_data = b_tx_data; sb_busy = b_busy; sb_aud_ready = b_aud_ready;
    pix_hs = pix_valid & pix_ready;
    aud_hs = aud_valid & aud_ready;
    chk("src_vs_tx_handshake", 32'(pix_hs | aud_hs), 32'(tx_valid & tx_ready));
    if (tx_valid && tx_ready) begin
      $display("xfer cyc=%0d type=%0d sof=%0d eof=%0d data=%02h", cyc, tx_type, tx_sof, tx_eof, tx_data);
      chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte", {21'd0, tx_type, tx_sof, tx_eof, tx_data}, {21'd0, e});
      end
      if (tx_sof) begin
        if (spacing_en && last_eof >= 0) begin
          chk("ifg_spacing", cyc - last_eof, IFG + 2);
          spacing_cnt++;
        end
        last_sof = cyc;
      end
      if (tx_eof) last_eof = cyc;
    end
    @(posedge clk);
    #1;
    if (pix_hs) pix_idx++;
    if (aud_hs) aud_idx++;
    pix_data = 8'(8'hA0 + pix_idx);
    aud_data = 8'(8'hC0 + aud_idx);
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || s_busy) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < bound), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, req_cyc;
    logic leak;

    rst = 1'b1;
    pix_req = 0; pix_valid = 0; pix_data = 8'hA0;
    aud_req = 0; aud_valid = 0; aud_data = 8'hC0;
    tx_ready = 1'b1;
    b_pix_req = 0; b_pix_valid = 0; b_pix_data = 8'h00;
    b_aud_req = 0; b_aud_valid = 0; b_aud_data = 8'h5A; b_tx_ready = 1'b1;
    tick();
    tick();

    // Reset state of both instances.
    chk("rst_outputs", {17'd0, s_tx_valid, s_tx_sof, s_tx_eof, s_tx_type, s_pix_ready, s_aud_ready, s_busy, s_tx_data}, 32'd0);
    chk("rst_outputs_b", {18'd0, sb_tx_valid, sb_tx_sof, sb_tx_eof, sb_tx_type, sb_aud_ready, sb_busy, sb_tx_data}, 32'd0);
    rst = 1'b0;

    // Pixel-only frame A0..A3 back-to-back, then the gap.
    push_frame(1'b0, 0, 4);
    pix_req = 1'b1; pix_valid = 1'b1;
    tick();
    req_cyc = cyc;
    chk("idle_before_grant", 32'(s_busy), 32'd0);
    pix_req = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    chk("t1_drain", 32'(n < 50), 32'd1);
    chk("t1_first_byte_latency", last_sof - req_cyc, 1);
    chk("t1_burst_len", last_eof - last_sof, 3);
    gap = 0; leak = 1'b0; n = 0;
    do begin
      tick();
      if (s_busy) gap++;
      leak = leak | s_tx_valid | s_pix_ready | s_aud_ready;
      n++;
    end while (s_busy && n < 100);
    chk("t1_gap_cycles", gap, IFG);
    chk("t1_gap_quiet", 32'(leak), 32'd0);

    // Packager stall of 3 cycles on the third byte.
    push_frame(1'b0, 4, 4);
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    tick();
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", 32'(s_tx_data), 32'hA6);
      chk("stall_pix_ready", 32'(s_pix_ready), 32'd0);
      chk("stall_valid", 32'(s_tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    drain("stall_drain", 100);

    // Reset while the third audio byte is on the bus.
    exp_q.push_back({1'b1, 1'b1, 1'b0, 8'hC0});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hC1});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hC2});
    aud_req = 1'b1; aud_valid = 1'b1;
    tick();
    aud_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_outputs", {17'd0, s_tx_valid, s_tx_sof, s_tx_eof, s_tx_type, s_pix_ready, s_aud_ready, s_busy, s_tx_data}, 32'd0);
    chk("midrst_q_empty", exp_q.size(), 0);

    // Both requests held: three frames with fixed eof-to-sof spacing.
`ifdef ETH_AUDIO_PRIORITY_EN
    push_frame(1'b1, 3, 4);
    push_frame(1'b1, 7, 4);
    push_frame(1'b1, 11, 4);
`else
    push_frame(1'b0, 8, 4);
    push_frame(1'b1, 3, 4);
    push_frame(1'b0, 12, 4);
`endif
    spacing_en = 1'b1; last_eof = -1; spacing_cnt = 0;
    pix_req = 1'b1; aud_req = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    chk("tie_drain", 32'(n < 400), 32'd1);
    pix_req = 1'b0; aud_req = 1'b0;
    spacing_en = 1'b0;
    chk("tie_spacing_count", spacing_cnt, 2);
    drain("tie_idle", 100);

    // Single-byte audio frame on the second instance.
    b_aud_req = 1'b1; b_aud_valid = 1'b1;
    tick();
    chk("n1_idle_first", 32'(sb_busy), 32'd0);
    b_aud_req = 1'b0;
    tick();
    chk("n1_byte", {19'd0, sb_tx_valid, sb_tx_sof, sb_tx_eof, sb_tx_type, sb_aud_ready, sb_tx_data}, {19'd0, 5'b11111, 8'h5A});
    tick();
    chk("n1_gap", {30'd0, sb_busy, sb_tx_valid}, 32'd2);
    for (int i = 0; i < 4; i++) tick();
    chk("n1_idle_after_gap", 32'(sb_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
